// File: rtl/monitor_reator_param.sv
// Reactor temperature monitor: sliding-window average -> hysteresis -> 5-state escalation FSM.
// Actuators follow one clock after the sample edge; define ALARME_TRAVADO_EN to latch ALARME until acknowledged.
module monitor_reator_param #(
  parameter int WIDTH        = 9,
  parameter int DEPTH_LOG2   = 2,
  parameter int LIMIAR_ALTO  = 300,
  parameter int LIMIAR_BAIXO = 280
) (
  input  logic             CLOCK,
  input  logic             reset,
  input  logic [WIDTH-1:0] tempRea,
  input  logic             amostra_valida,
`ifdef ALARME_TRAVADO_EN
  input  logic             reconhecer,
`endif
  output logic [WIDTH-1:0] media,
  output logic             media_valida,
  output logic [2:0]       estado,
  output logic             sistemaDeResfriamento,
  output logic             portasDeConcreto,
  output logic             alarmeSonoroReator
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int SW    = WIDTH + DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [WIDTH:0] ALTO  = (WIDTH + 1)'(LIMIAR_ALTO);
  localparam logic [WIDTH:0] BAIXO = (WIDTH + 1)'(LIMIAR_BAIXO);

  localparam logic [2:0] NORMAL     = 3'd0;
  localparam logic [2:0] ALERTA     = 3'd1;
  localparam logic [2:0] RESFRIANDO = 3'd2;
  localparam logic [2:0] PORTAS     = 3'd3;
  localparam logic [2:0] ALARME     = 3'd4;

  logic [WIDTH-1:0]    janela [DEPTH];
  logic [SW-1:0]       soma, soma_next;
  logic [DEPTH_LOG2:0] cnt, cnt_next;
  logic                passo;
  logic                quente, quente_next;
  logic [2:0]          estado_next;
  logic                libera_alarme;

  // Intermediate wrap is harmless: the true sum always fits in SW bits.
  assign soma_next = soma + SW'(tempRea) - SW'(janela[DEPTH-1]);
  assign cnt_next  = (cnt == DEPTH_CNT) ? cnt : cnt + 1'b1;

  always_ff @(posedge CLOCK or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) janela[i] <= '0;
      soma         <= '0;
      cnt          <= '0;
      media        <= '0;
      media_valida <= 1'b0;
      passo        <= 1'b0;
    end else begin
      passo <= amostra_valida;
      if (amostra_valida) begin
        janela[0] <= tempRea;
        for (int i = 1; i < DEPTH; i++) janela[i] <= janela[i-1];
        soma         <= soma_next;
        cnt          <= cnt_next;
        media        <= WIDTH'(soma_next >> DEPTH_LOG2);
        media_valida <= (cnt_next == DEPTH_CNT);
      end
    end
  end

  always_comb begin
    quente_next = quente;
    if (!media_valida)
      quente_next = 1'b0;
    else if ({1'b0, media} >= ALTO)
      quente_next = 1'b1;
    else if ({1'b0, media} < BAIXO)
      quente_next = 1'b0;
  end

`ifdef ALARME_TRAVADO_EN
  logic ack;

  always_ff @(posedge CLOCK or negedge reset) begin
    if (!reset)
      ack <= 1'b0;
    else if (estado_next != ALARME)
      ack <= 1'b0;
    else if (estado == ALARME && !quente && reconhecer)
      ack <= 1'b1;
  end

  assign libera_alarme = ack;
`else
  assign libera_alarme = 1'b1;
`endif

  always_comb begin
    estado_next = estado;
    case (estado)
      NORMAL:     if (passo) estado_next = quente_next ? ALERTA : NORMAL;
      ALERTA:     if (passo) estado_next = quente_next ? PORTAS : RESFRIANDO;
      RESFRIANDO: if (passo) estado_next = quente_next ? ALERTA : NORMAL;
      PORTAS:     if (passo) estado_next = quente_next ? ALARME : RESFRIANDO;
      ALARME:     if (passo && !quente_next && libera_alarme) estado_next = RESFRIANDO;
      default:    estado_next = NORMAL;
    endcase
  end

  // Actuators are registered from the next state so they change on the same edge as estado.
  always_ff @(posedge CLOCK or negedge reset) begin
    if (!reset) begin
      quente                <= 1'b0;
      estado                <= NORMAL;
      sistemaDeResfriamento <= 1'b0;
      portasDeConcreto      <= 1'b0;
      alarmeSonoroReator    <= 1'b0;
    end else begin
      if (passo) quente <= quente_next;
      estado                <= estado_next;
      sistemaDeResfriamento <= (estado_next == ALERTA) || (estado_next == RESFRIANDO) ||
                               (estado_next == PORTAS) || (estado_next == ALARME);
      portasDeConcreto      <= (estado_next == PORTAS) || (estado_next == ALARME);
      alarmeSonoroReator    <= (estado_next == ALARME);
    end
  end

endmodule

// File: tb/tb_monitor_reator_param.sv
// Directed bench for monitor_reator_param with default parameters (window of 4, thresholds 300/280).
`timescale 1ns/1ps
module tb_monitor_reator_param;

  logic       CLOCK = 1'b0;
  logic       clk_en = 1'b0;
  logic       reset;
  logic [8:0] tempRea;
  logic       amostra_valida;
  logic [8:0] media;
  logic       media_valida;
  logic [2:0] estado;
  logic       sistemaDeResfriamento;
  logic       portasDeConcreto;
  logic       alarmeSonoroReator;
`ifdef ALARME_TRAVADO_EN
  logic       reconhecer = 1'b0;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  monitor_reator_param dut (
    .CLOCK                 (CLOCK),
    .reset                 (reset),
    .tempRea               (tempRea),
    .amostra_valida        (amostra_valida),
`ifdef ALARME_TRAVADO_EN
    .reconhecer            (reconhecer),
`endif
    .media                 (media),
    .media_valida          (media_valida),
    .estado                (estado),
    .sistemaDeResfriamento (sistemaDeResfriamento),
    .portasDeConcreto      (portasDeConcreto),
    .alarmeSonoroReator    (alarmeSonoroReator)
  );

  always begin
    #5;
    if (clk_en) CLOCK = ~CLOCK;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic check_out(input string tag, input int e, input int r, input int p, input int a);
    check({tag, ".estado"}, estado, e);
    check({tag, ".resfr"}, sistemaDeResfriamento, r);
    check({tag, ".portas"}, portasDeConcreto, p);
    check({tag, ".alarme"}, alarmeSonoroReator, a);
  endtask

  // One clock: drive inputs, take the edge, settle 1 ns past it.
  task automatic cyc(input logic v, input logic [8:0] t);
    amostra_valida = v;
    tempRea        = t;
    @(posedge CLOCK);
    #1;
  endtask

  // Sample edge followed by its step edge.
  task automatic sample(input logic [8:0] t);
    cyc(1'b1, t);
    cyc(1'b0, 9'd0);
  endtask

  initial begin
    reset          = 1'b0;
    amostra_valida = 1'b0;
    tempRea        = '0;
    #2;
    check_out("reset_stopped", 0, 0, 0, 0);
    check("reset_stopped.media", media, 0);
    check("reset_stopped.mv", media_valida, 0);

    clk_en = 1'b1;
    @(posedge CLOCK);
    #2 reset = 1'b1;
    @(posedge CLOCK);
    #1;

    // Fill phase
    sample(9'd400);
    check("fill1.media", media, 100);
    sample(9'd400);
    check("fill2.media", media, 200);
    sample(9'd400);
    check("fill3.media", media, 300);
    check("fill3.mv", media_valida, 0);
    check_out("fill3", 0, 0, 0, 0);
    cyc(1'b1, 9'd400);
    check("fill4.media", media, 400);
    check("fill4.mv", media_valida, 1);
    check_out("fill4_e0", 0, 0, 0, 0);
    cyc(1'b0, 9'd0);
    check_out("fill4_e1", 1, 1, 0, 0);

    // Escalation and cool-down
    sample(9'd400);
    check_out("esc_portas", 3, 1, 1, 0);
    sample(9'd400);
    check_out("esc_alarme", 4, 1, 1, 1);
    sample(9'd100);
    check("cool1.media", media, 325);
    check_out("cool1", 4, 1, 1, 1);
    sample(9'd100);
    check("cool2.media", media, 250);
    check_out("cool2", 2, 1, 0, 0);
    sample(9'd100);
    check_out("cool3", 0, 0, 0, 0);
    sample(9'd100);
    check("cool4.media", media, 100);
    check_out("cool4", 0, 0, 0, 0);

    // Hysteresis boundaries
    sample(9'd300);
    sample(9'd300);
    sample(9'd300);
    check_out("hyst_pre", 0, 0, 0, 0);
    sample(9'd300);
    check("hyst300.media", media, 300);
    check_out("hyst300", 1, 1, 0, 0);
    sample(9'd260);
    check("hyst290.media", media, 290);
    check_out("hyst290_hot", 3, 1, 1, 0);
    sample(9'd256);
    check("hyst279.media", media, 279);
    check_out("hyst279", 2, 1, 0, 0);
    sample(9'd344);
    check("cold290.media", media, 290);
    check_out("cold290a", 0, 0, 0, 0);
    sample(9'd300);
    check("cold290b.media", media, 290);
    check_out("cold290b", 0, 0, 0, 0);

    // Idle cycles hold window and FSM
    cyc(1'b1, 9'd400);
    check("idle_s1.media", media, 325);
    check_out("idle_s1", 0, 0, 0, 0);
    cyc(1'b0, 9'd0);
    check_out("idle_step1", 1, 1, 0, 0);
    cyc(1'b0, 9'd0);
    check("idle_hold.media", media, 325);
    check_out("idle_hold", 1, 1, 0, 0);
    cyc(1'b1, 9'd400);
    check("idle_s2.media", media, 361);
    check_out("idle_s2", 1, 1, 0, 0);
    cyc(1'b0, 9'd0);
    check_out("idle_step2", 3, 1, 1, 0);
    sample(9'd400);
    check("pre_rst.media", media, 375);
    check_out("pre_rst", 4, 1, 1, 1);

    // Asynchronous reset in ALARME, then full refill
    reset = 1'b0;
    #1;
    check_out("mid_rst", 0, 0, 0, 0);
    check("mid_rst.media", media, 0);
    check("mid_rst.mv", media_valida, 0);
    #1 reset = 1'b1;
    sample(9'd400);
    check("refill1.media", media, 100);
    check("refill1.mv", media_valida, 0);
    sample(9'd400);
    sample(9'd400);
    check("refill3.media", media, 300);
    check("refill3.mv", media_valida, 0);
    check_out("refill3", 0, 0, 0, 0);
    sample(9'd400);
    check("refill4.mv", media_valida, 1);
    check_out("refill4", 1, 1, 0, 0);
    sample(9'd400);
    sample(9'd400);
    check_out("lat_alarme", 4, 1, 1, 1);
    sample(9'd100);
    check_out("lat_325", 4, 1, 1, 1);
    sample(9'd100);
    check("lat_250.media", media, 250);
`ifdef ALARME_TRAVADO_EN
    check_out("lat_250", 4, 1, 1, 1);
    sample(9'd100);
    check_out("lat_175", 4, 1, 1, 1);
    reconhecer = 1'b1;
    cyc(1'b0, 9'd0);
    reconhecer = 1'b0;
    check_out("lat_ack", 4, 1, 1, 1);
    sample(9'd100);
    check_out("lat_release", 2, 1, 0, 0);
`else
    check_out("lat_250", 2, 1, 0, 0);
    sample(9'd100);
    check_out("lat_175", 0, 0, 0, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
